// File: rtl/hoeraa_error_monitor.sv
// Error-characterization monitor for the HOERAA approximate adder: accepts (X, Y, S, Co)
// samples over a valid/ready handshake and accumulates error-distance statistics per run.
module hoeraa_error_monitor #(
   parameter int unsigned N           = 16,
   parameter int unsigned K           = 12,
   parameter int unsigned NUM_SAMPLES = 1024,
   parameter int unsigned ACC_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N-1:0]     X,
   input  logic [N-1:0]     Y,
   input  logic [N-1:0]     S,
   input  logic             Co,
   output logic             busy,
   output logic             done,
   output logic [ACC_W-1:0] sample_count,
   output logic [ACC_W-1:0] err_count,
   output logic [ACC_W-1:0] sum_ed,
   output logic [N:0]       max_ed,
   output logic             hi_err
);

   localparam int unsigned CntW = $clog2(NUM_SAMPLES + 1);
   // Wide enough that one add of ED to the accumulator cannot wrap before the saturation test.
   localparam int unsigned SumW = ((ACC_W > N + 1) ? ACC_W : N + 1) + 1;
   localparam logic [CntW-1:0] LastIdx = CntW'(NUM_SAMPLES - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] run_cnt_q, run_cnt_d;
   logic            drain_q, drain_d;
   logic            in_ready_q;
   logic            accept;

   logic            s1_valid_q;
   logic [N:0]      s1_exact_q, s1_approx_q;

   logic [ACC_W-1:0] sample_count_q, err_count_q, sum_ed_q;
   logic [N:0]       max_ed_q;
   logic             hi_err_q;

   logic [N:0]       ed;
   logic             hi_diff;
   logic [SumW-1:0]  sum_wide;
   logic [ACC_W-1:0] sum_sat;

   assign in_ready = in_ready_q & ~start;
   assign accept   = in_valid & in_ready;
   assign busy     = (state_q == StRun) || (state_q == StDrain);
   assign done     = (state_q == StDone);

   always_comb begin
      state_d   = state_q;
      run_cnt_d = run_cnt_q;
      drain_d   = drain_q;
      if (start) begin
         state_d   = StRun;
         run_cnt_d = '0;
         drain_d   = 1'b0;
      end else begin
         case (state_q)
            StIdle: ;
            StRun: begin
               if (accept) begin
                  run_cnt_d = run_cnt_q + CntW'(1);
                  if (run_cnt_q == LastIdx) begin
                     state_d = StDrain;
                     drain_d = 1'b0;
                  end
               end
            end
            // drain_q marks the second drain cycle, after which stage 2 has retired.
            StDrain: begin
               drain_d = 1'b1;
               if (drain_q) state_d = StDone;
            end
            StDone: ;
            default: state_d = StIdle;
         endcase
      end
   end

   always_comb begin
      ed       = (s1_exact_q >= s1_approx_q) ? (s1_exact_q - s1_approx_q)
                                             : (s1_approx_q - s1_exact_q);
      hi_diff  = (s1_exact_q[N:K] != s1_approx_q[N:K]);
      sum_wide = SumW'(sum_ed_q) + SumW'(ed);
      sum_sat  = (|sum_wide[SumW-1:ACC_W]) ? '1 : sum_wide[ACC_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= StIdle;
         run_cnt_q      <= '0;
         drain_q        <= 1'b0;
         in_ready_q     <= 1'b0;
         s1_valid_q     <= 1'b0;
         s1_exact_q     <= '0;
         s1_approx_q    <= '0;
         sample_count_q <= '0;
         err_count_q    <= '0;
         sum_ed_q       <= '0;
         max_ed_q       <= '0;
         hi_err_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         run_cnt_q  <= run_cnt_d;
         drain_q    <= drain_d;
         in_ready_q <= (state_d == StRun);
         // accept is low whenever start is high, so a restart also flushes stage 1.
         s1_valid_q <= accept;
         if (accept) begin
            s1_exact_q  <= {1'b0, X} + {1'b0, Y};
            s1_approx_q <= {Co, S};
         end
         if (start) begin
            sample_count_q <= '0;
            err_count_q    <= '0;
            sum_ed_q       <= '0;
            max_ed_q       <= '0;
            hi_err_q       <= 1'b0;
         end else begin
            if (accept && (sample_count_q != '1)) sample_count_q <= sample_count_q + ACC_W'(1);
            if (s1_valid_q) begin
               if ((ed != '0) && (err_count_q != '1)) err_count_q <= err_count_q + ACC_W'(1);
               sum_ed_q <= sum_sat;
               if (ed > max_ed_q) max_ed_q <= ed;
               if (hi_diff) hi_err_q <= 1'b1;
            end
         end
      end
   end

   assign sample_count = sample_count_q;
   assign err_count    = err_count_q;
   assign sum_ed       = sum_ed_q;
   assign max_ed       = max_ed_q;
   assign hi_err       = hi_err_q;

endmodule
